// File: rtl/isa_pkg.sv
// ============================================================================
// Module      : isa_pkg
// Description : Shared instruction-store constants and loader state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package isa_pkg;

    localparam int ADDR_W = 8;
    localparam int INST_W = 9;
    localparam int DEPTH  = 256;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_LO = 3'd1,
        ST_LOAD_HI = 3'd2,
        ST_CHECK   = 3'd3,
        ST_FIRE    = 3'd4,
        ST_RUN     = 3'd5,
        ST_ERROR   = 3'd6
    } loader_state_t;

endpackage

`default_nettype wire

// File: rtl/inst_loader_if.sv
// ============================================================================
// Module      : inst_loader_if
// Description : Byte-stream input and instruction-RAM write port of the loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface inst_loader_if;
    import isa_pkg::*;

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_last;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [INST_W-1:0] wr_data;

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, wr_en, wr_addr, wr_data
    );

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, wr_en, wr_addr, wr_data
    );

endinterface

`default_nettype wire

// File: rtl/inst_loader_chk.sv
// ============================================================================
// Module      : inst_loader_chk
// Description : XOR accumulator over accepted program bytes with compare.
//               Present only when INST_LOADER_CHECKSUM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef INST_LOADER_CHECKSUM_EN
module inst_loader_chk (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clr,
    input  logic       i_acc,
    input  logic [7:0] i_data,
    output logic       o_match
);

    logic [7:0] r_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum <= 8'h00;
        end else if (i_clr) begin
            r_sum <= 8'h00;
        end else if (i_acc) begin
            r_sum <= r_sum ^ i_data;
        end
    end

    assign o_match = (i_data == r_sum);

endmodule
`endif

`default_nettype wire

// File: rtl/inst_loader.sv
// ============================================================================
// Module      : inst_loader
// Description : Packs byte pairs into 9-bit instructions, writes them to the
//               instruction RAM, then pulses start and waits for halt.
//               Optional checksum byte: define INST_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_loader
    import isa_pkg::*;
(
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            load_en,
    input  logic            halt,
    inst_loader_if.slave    bus,
    output logic            start,
    output logic            busy,
    output logic            err,
    output logic [ADDR_W:0] inst_count
);

    localparam logic [ADDR_W:0] c_FULL = (ADDR_W + 1)'(DEPTH);

    loader_state_t     r_state;
    loader_state_t     w_next;
    logic              w_accept;
    logic              w_session;
    logic              w_write;
    logic [7:0]        r_lo;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [INST_W-1:0] r_wr_data;
    logic              r_start;

    assign bus.in_ready = (r_state == ST_LOAD_LO) || (r_state == ST_LOAD_HI) ||
                          (r_state == ST_CHECK);
    assign w_accept     = bus.in_valid & bus.in_ready;

`ifdef INST_LOADER_CHECKSUM_EN
    logic w_chk_match;
    logic w_chk_acc;

    // Only program bytes feed the sum; the checksum byte itself is compared.
    assign w_chk_acc = w_accept & ((r_state == ST_LOAD_LO) || (r_state == ST_LOAD_HI));

    inst_loader_chk u_chk (
        .clk     (CLK),
        .rst_n   (RESET_N),
        .i_clr   (w_session),
        .i_acc   (w_chk_acc),
        .i_data  (bus.in_data),
        .o_match (w_chk_match)
    );
`endif

    always_comb begin
        w_next    = r_state;
        w_session = 1'b0;
        w_write   = 1'b0;
        case (r_state)
            ST_IDLE, ST_ERROR: begin
                if (load_en) begin
                    w_next    = ST_LOAD_LO;
                    w_session = 1'b1;
                end
            end
            ST_LOAD_LO: begin
                if (w_accept) begin
                    w_next = bus.in_last ? ST_ERROR : ST_LOAD_HI;
                end
            end
            ST_LOAD_HI: begin
                if (w_accept) begin
                    // A full store rejects further instructions rather than wrapping.
                    if (r_count == c_FULL) begin
                        w_next = ST_ERROR;
                    end else begin
                        w_write = 1'b1;
                        if (bus.in_last) begin
`ifdef INST_LOADER_CHECKSUM_EN
                            w_next = ST_CHECK;
`else
                            w_next = ST_FIRE;
`endif
                        end else begin
                            w_next = ST_LOAD_LO;
                        end
                    end
                end
            end
            ST_CHECK: begin
`ifdef INST_LOADER_CHECKSUM_EN
                if (w_accept) begin
                    w_next = w_chk_match ? ST_FIRE : ST_ERROR;
                end
`else
                w_next = ST_IDLE;
`endif
            end
            ST_FIRE:  w_next = ST_RUN;
            ST_RUN: begin
                if (halt) begin
                    w_next = ST_IDLE;
                end
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= ST_IDLE;
            r_lo      <= 8'h00;
            r_addr    <= '0;
            r_count   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_start   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wr_en <= w_write;
            // Delayed by one so the pulse never overlaps the final write strobe.
            r_start <= (r_state == ST_FIRE);
            if (w_session) begin
                r_addr  <= '0;
                r_count <= '0;
            end
            if ((r_state == ST_LOAD_LO) && w_accept) begin
                r_lo <= bus.in_data;
            end
            if (w_write) begin
                r_wr_addr <= r_addr;
                r_wr_data <= {bus.in_data[0], r_lo};
                r_addr    <= r_addr + 1'b1;
                r_count   <= r_count + 1'b1;
            end
        end
    end

    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign start       = r_start;
    assign busy        = (r_state != ST_IDLE);
    assign err         = (r_state == ST_ERROR);
    assign inst_count  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_inst_loader.sv
// ============================================================================
// Module      : tb_inst_loader
// Description : Scoreboard bench for inst_loader with a program-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_inst_loader;
    import isa_pkg::*;

    logic            CLK = 1'b0;
    logic            RESET_N = 1'b0;
    logic            load_en = 1'b0;
    logic            halt = 1'b0;
    logic            start;
    logic            busy;
    logic            err;
    logic [ADDR_W:0] inst_count;

    inst_loader_if bus();

    inst_loader dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .load_en    (load_en),
        .halt       (halt),
        .bus        (bus.slave),
        .start      (start),
        .busy       (busy),
        .err        (err),
        .inst_count (inst_count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_wr[$];
    int  exp_start[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pop the next expected write / start whenever the DUT shows one.
    wr_t e;
    always @(negedge CLK) begin
        if (RESET_N) begin
            if (bus.wr_en) begin
                chk("wr_expected", int'(exp_wr.size() > 0), 1);
                if (exp_wr.size() > 0) begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", int'(bus.wr_addr), e.addr);
                    chk("wr_data", int'(bus.wr_data), e.data);
                end
            end
            if (start) begin
                chk("start_not_with_wr", int'(bus.wr_en), 0);
                chk("start_expected", int'(exp_start.size() > 0), 1);
                if (exp_start.size() > 0) void'(exp_start.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last, input bit gaps);
        int cyc = 0;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                bus.in_last  = 1'($urandom);
                @(posedge CLK); #1;
            end
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        bus.in_last  = last;
        while (!bus.in_ready && cyc < 50) begin
            @(posedge CLK); #1;
            cyc++;
        end
        if (cyc >= 50) begin
            n_vec++;
            n_err++;
            $display("FAIL byte_accept_timeout: actual=stalled required=accepted");
        end
        @(posedge CLK); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic open_session();
        @(posedge CLK); #1;
        load_en = 1'b1;
        @(posedge CLK); #1;
        load_en = 1'b0;
        chk("err_cleared", int'(err), 0);
        chk("busy_loading", int'(busy), 1);
    endtask

    // Program-level model: pairs -> instructions, odd length / overflow / bad sum -> error.
    task automatic run_session(input logic [7:0] prog[$], input bit mark_last,
                               input bit gaps, input bit bad_csum);
        logic [7:0] tx[$];
        bit         txl[$];
        bit         ok = 1'b0;
        bit         stop = 1'b0;
        int         n_inst = 0;
        logic [7:0] x = 8'h00;
        for (int i = 0; i < prog.size() && !stop; i++) begin
            bit is_last = mark_last && (i == prog.size() - 1);
            tx.push_back(prog[i]);
            txl.push_back(is_last);
            x ^= prog[i];
            if (i % 2 == 0) begin
                if (is_last) stop = 1'b1;
            end else if (n_inst == DEPTH) begin
                stop = 1'b1;
            end else begin
                exp_wr.push_back('{n_inst, int'({prog[i][0], prog[i-1]})});
                n_inst++;
                if (is_last) begin
                    ok   = 1'b1;
                    stop = 1'b1;
                end
            end
        end
`ifdef INST_LOADER_CHECKSUM_EN
        if (ok) begin
            tx.push_back(bad_csum ? (x ^ 8'h07) : x);
            txl.push_back(1'b0);
            ok = !bad_csum;
        end
`endif
        if (ok) exp_start.push_back(1);
        open_session();
        for (int i = 0; i < tx.size(); i++) send_byte(tx[i], txl[i], gaps);
        repeat (5) @(posedge CLK);
        #1;
        chk("wr_queue_drained", exp_wr.size(), 0);
        chk("start_seen", exp_start.size(), 0);
        chk("inst_count", int'(inst_count), n_inst);
        chk("err", int'(err), int'(!ok));
        chk("busy_after_load", int'(busy), 1);
        chk("in_ready_after_load", int'(bus.in_ready), 0);
        if (ok) begin
            // halt wins; a coincident load_en must not reopen a session.
            halt    = 1'b1;
            load_en = 1'b1;
            @(posedge CLK); #1;
            halt    = 1'b0;
            load_en = 1'b0;
            chk("busy_after_halt", int'(busy), 0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, int'(bus.in_ready), 0);
        chk({tag, "_wr_en"}, int'(bus.wr_en), 0);
        chk({tag, "_wr_addr"}, int'(bus.wr_addr), 0);
        chk({tag, "_wr_data"}, int'(bus.wr_data), 0);
        chk({tag, "_start"}, int'(start), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_inst_count"}, int'(inst_count), 0);
        chk({tag, "_err"}, int'(err), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] p[$];
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_last  = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk_all_zero("reset");
        RESET_N = 1'b1;

        p = '{8'h12, 8'h01, 8'h34, 8'h00};
        run_session(p, 1'b1, 1'b0, 1'b0);

        p = '{8'hAA};
        run_session(p, 1'b1, 1'b0, 1'b0);

        p = {};
        for (int i = 0; i < 2 * (DEPTH + 1); i++) p.push_back(8'($urandom));
        run_session(p, 1'b0, 1'b0, 1'b0);

        p = '{8'h5A, 8'h03, 8'hC3, 8'hFE, 8'h01, 8'h81};
        run_session(p, 1'b1, 1'b0, 1'b0);
        run_session(p, 1'b1, 1'b1, 1'b0);

        p = '{8'h12, 8'h01};
        run_session(p, 1'b1, 1'b0, 1'b0);
        run_session(p, 1'b1, 1'b0, 1'b1);

        for (int s = 0; s < 6; s++) begin
            int n = $urandom_range(1, 6);
            p = {};
            for (int i = 0; i < 2 * n; i++) p.push_back(8'($urandom));
            if ($urandom_range(0, 3) == 0) void'(p.pop_back());
            run_session(p, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
        end

        // Reset after the first of three instructions: only that write survives.
        exp_wr.push_back('{0, int'({1'b1, 8'h77})});
        open_session();
        send_byte(8'h77, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0, 1'b0);
        @(posedge CLK); #3;
        RESET_N = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_idle", int'(busy), 0);
        chk("reset_wr_drained", exp_wr.size(), 0);

        p = '{8'h9C, 8'h00};
        run_session(p, 1'b1, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
